// File: rtl/rank_filter_pkg.sv
// rank_filter_pkg: configuration and shared types for the rank-order filter.
// R_WIDTH and N are set here and every other file takes them from this package.
// RK_W is derived from N and is not meant to be changed on its own.
// N must be odd and in the range 3..31.
package rank_filter_pkg;

  // Ceiling log2. Evaluated at elaboration time to size ports and counters.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  localparam int R_WIDTH     = 8;             // sample width, bits
  localparam int N           = 5;             // window length (odd)
  localparam int RK_W        = clog2(N);      // rank / age width
  localparam int CNT_W       = clog2(N + 1);  // fill counter width, holds 0..N
  localparam int RANK_MEDIAN = (N - 1) / 2;

  // Age of the entry that leaves the window on the next accepted sample.
  localparam logic [RK_W-1:0] AGE_OLDEST = RK_W'(N - 1);

  // One cell of the sorted window: sample value and how many samples ago it arrived.
  typedef struct packed {
    logic [R_WIDTH-1:0] value;
    logic [RK_W-1:0]    age;
  } slot_t;

  // Per-cell move chosen on an accepted sample.
  //   SLOT_SHIFT_L: take the right neighbour (entries slide toward index 0)
  //   SLOT_SHIFT_R: take the left neighbour  (entries slide toward index N-1)
  typedef enum logic [1:0] {
    SLOT_KEEP,
    SLOT_SHIFT_L,
    SLOT_SHIFT_R,
    SLOT_LOAD
  } slot_op_t;

endpackage

// File: rtl/rof_slot.sv
// rof_slot: one cell of the sorted sliding window.
// Decides its next entry from its own entry, both neighbours, the new sample and
// the location of the evicted entry. Every surviving entry ages by one; the new
// sample enters with age 0. Purely combinational; the top holds the registers.
module rof_slot
  import rank_filter_pkg::*;
(
  input  slot_t              own_i,
  input  slot_t              left_i,
  input  slot_t              right_i,
  input  logic [R_WIDTH-1:0] x_i,
  input  logic               own_gt_i,      // own value > new sample
  input  logic               left_gt_i,     // left value > new sample (0 at index 0)
  input  logic               right_gt_i,    // right value > new sample (1 at index N-1)
  input  logic               evict_le_i,    // evicted cell index <= this index
  input  logic               evict_ge_i,    // evicted cell index >= this index
  input  logic               evict_gt_x_i,  // evicted value > new sample
  output slot_t              next_o
);

  slot_op_t op;

  // Choose the move. If the evicted value is <= X the hole is left of the
  // insertion point, so the cells between slide left; otherwise the cells
  // between the insertion point and the hole slide right. Strict '>' places
  // X after existing equal values.
  always_comb begin
    // NOTE: assign a default before any branch so every path drives op; a
    // missing path in always_comb would infer a latch.
    op = SLOT_KEEP;
    if (evict_gt_x_i) begin
      if (evict_ge_i && own_gt_i) begin
        op = left_gt_i ? SLOT_SHIFT_R : SLOT_LOAD;
      end
    end else if (evict_le_i && !own_gt_i) begin
      op = right_gt_i ? SLOT_LOAD : SLOT_SHIFT_L;
    end
  end

  // Build the next entry. The evicted entry always lies inside the shifting
  // region, so aging a kept entry never wraps past N-1.
  always_comb begin
    next_o = '{value: own_i.value, age: own_i.age + RK_W'(1)};
    unique case (op)
      SLOT_SHIFT_L: next_o = '{value: right_i.value, age: right_i.age + RK_W'(1)};
      SLOT_SHIFT_R: next_o = '{value: left_i.value,  age: left_i.age  + RK_W'(1)};
      SLOT_LOAD:    next_o = '{value: x_i,           age: '0};
      default:      next_o = '{value: own_i.value,   age: own_i.age   + RK_W'(1)};
    endcase
  end

endmodule

// File: rtl/rank_order_filter.sv
// rank_order_filter: streaming 1-D rank-order filter over the last N samples.
// Pipeline: input register -> sorted-window update -> order-statistic select.
// A sample accepted at edge k shows up on Y/y_valid at edge k+2.
// Optional feature macro: RANK_FILTER_STATS_EN adds Y_MIN / Y_MAX outputs.
module rank_order_filter
  import rank_filter_pkg::*;
(
  input  logic               clk,
  input  logic               srst,
  input  logic               x_valid,
  input  logic [R_WIDTH-1:0] X,
  input  logic [RK_W-1:0]    rank,
  output logic               y_valid,
  output logic [R_WIDTH-1:0] Y
`ifdef RANK_FILTER_STATS_EN
  ,
  output logic [R_WIDTH-1:0] Y_MIN,
  output logic [R_WIDTH-1:0] Y_MAX
`endif
);

  // Stage 0: registered inputs
  logic               in_valid_q;
  logic [R_WIDTH-1:0] in_x_q;
  logic [RK_W-1:0]    in_rank_q;

  // Stage 1: sorted window, fill counter, rank travelling with the sample
  slot_t              slot_q [N];
  slot_t              slot_d [N];
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sel_valid_q, sel_valid_d;
  logic [RK_W-1:0]    sel_rank_q;

  // Stage 2: outputs
  logic               y_valid_q;
  logic [R_WIDTH-1:0] y_q;
  logic [RK_W-1:0]    sel_idx;

  // Window compare signals
  logic [N-1:0]       gt;         // slot value > incoming sample
  logic [N-1:0]       evict_hit;  // slot holds the oldest entry
  logic [N-1:0]       evict_le;   // evicted index <= i
  logic [N-1:0]       evict_ge;   // evicted index >= i
  logic               evict_gt_x;

  // Compare every slot against the incoming sample and locate the oldest entry.
  always_comb begin
    gt         = '0;
    evict_hit  = '0;
    evict_le   = '0;
    evict_ge   = '0;
    evict_gt_x = 1'b0;
    for (int i = 0; i < N; i++) begin
      gt[i]        = slot_q[i].value > in_x_q;
      evict_hit[i] = slot_q[i].age == AGE_OLDEST;
      if (evict_hit[i] && gt[i]) evict_gt_x = 1'b1;
    end
    evict_le[0] = evict_hit[0];
    for (int i = 1; i < N; i++) evict_le[i] = evict_le[i-1] | evict_hit[i];
    evict_ge[N-1] = evict_hit[N-1];
    for (int i = N - 2; i >= 0; i--) evict_ge[i] = evict_ge[i+1] | evict_hit[i];
  end

  // One cell per window position; the ends see a fixed "not greater" on the
  // left and "greater" on the right so X lands at the boundary correctly.
  for (genvar i = 0; i < N; i++) begin : g_slot
    slot_t left_e, right_e;
    logic  left_gt, right_gt;

    if (i == 0) begin : g_first
      assign left_e  = slot_q[i];
      assign left_gt = 1'b0;
    end else begin : g_left
      assign left_e  = slot_q[i-1];
      assign left_gt = gt[i-1];
    end

    if (i == N - 1) begin : g_last
      assign right_e  = slot_q[i];
      assign right_gt = 1'b1;
    end else begin : g_right
      assign right_e  = slot_q[i+1];
      assign right_gt = gt[i+1];
    end

    rof_slot u_slot (
      .own_i        (slot_q[i]),
      .left_i       (left_e),
      .right_i      (right_e),
      .x_i          (in_x_q),
      .own_gt_i     (gt[i]),
      .left_gt_i    (left_gt),
      .right_gt_i   (right_gt),
      .evict_le_i   (evict_le[i]),
      .evict_ge_i   (evict_ge[i]),
      .evict_gt_x_i (evict_gt_x),
      .next_o       (slot_d[i])
    );
  end

  // Capture the incoming sample and its rank; reset drops anything in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!srst) begin
      in_valid_q <= 1'b0;
      in_x_q     <= '0;
      in_rank_q  <= RK_W'(RANK_MEDIAN);
    end else begin
      in_valid_q <= x_valid;
      in_x_q     <= X;
      in_rank_q  <= rank;
    end
  end

  // Saturating fill count; a result is produced only once the window is full.
  always_comb begin
    cnt_d = cnt_q;
    if (in_valid_q && (cnt_q != CNT_W'(N))) cnt_d = cnt_q + CNT_W'(1);
    sel_valid_d = in_valid_q && (cnt_d == CNT_W'(N));
  end

  // Update the sorted window on each registered sample.
  always_ff @(posedge clk) begin
    // NOTE: the window is reset, not left uninitialised: the starting ages
    // 0..N-1 define the eviction order, so they must be known after reset.
    if (!srst) begin
      for (int i = 0; i < N; i++) slot_q[i] <= '{value: '0, age: RK_W'(i)};
      cnt_q       <= '0;
      sel_valid_q <= 1'b0;
      sel_rank_q  <= '0;
    end else begin
      if (in_valid_q) slot_q <= slot_d;
      cnt_q       <= cnt_d;
      sel_valid_q <= sel_valid_d;
      sel_rank_q  <= in_rank_q;
    end
  end

  // Clamp out-of-range ranks to the maximum.
  always_comb begin
    sel_idx = (sel_rank_q >= RK_W'(N)) ? RK_W'(N - 1) : sel_rank_q;
  end

`ifdef RANK_FILTER_STATS_EN
  logic [R_WIDTH-1:0] y_min_q, y_max_q;

  // Register the selected statistic plus window min/max; hold between results.
  always_ff @(posedge clk) begin
    if (!srst) begin
      y_valid_q <= 1'b0;
      y_q       <= '0;
      y_min_q   <= '0;
      y_max_q   <= '0;
    end else begin
      y_valid_q <= sel_valid_q;
      if (sel_valid_q) begin
        y_q     <= slot_q[sel_idx].value;
        y_min_q <= slot_q[0].value;
        y_max_q <= slot_q[N-1].value;
      end
    end
  end

  assign Y_MIN = y_min_q;
  assign Y_MAX = y_max_q;
`else
  // Register the selected statistic; hold Y between results.
  always_ff @(posedge clk) begin
    if (!srst) begin
      y_valid_q <= 1'b0;
      y_q       <= '0;
    end else begin
      y_valid_q <= sel_valid_q;
      if (sel_valid_q) y_q <= slot_q[sel_idx].value;
    end
  end
`endif

  assign y_valid = y_valid_q;
  assign Y       = y_q;

endmodule

// File: tb/tb_rank_order_filter.sv
// tb_rank_order_filter: directed and random stimulus for rank_order_filter with
// a sorted-queue reference model delayed by two clocks.
module tb_rank_order_filter;
  import rank_filter_pkg::*;

  logic               clk = 1'b0;
  logic               srst = 1'b0;
  logic               x_valid = 1'b0;
  logic [R_WIDTH-1:0] X = '0;
  logic [RK_W-1:0]    rank = RK_W'(RANK_MEDIAN);
  logic               y_valid;
  logic [R_WIDTH-1:0] Y;
`ifdef RANK_FILTER_STATS_EN
  logic [R_WIDTH-1:0] Y_MIN, Y_MAX;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rank_order_filter dut (
    .clk     (clk),
    .srst    (srst),
    .x_valid (x_valid),
    .X       (X),
    .rank    (rank),
    .y_valid (y_valid),
    .Y       (Y)
`ifdef RANK_FILTER_STATS_EN
    ,
    .Y_MIN   (Y_MIN),
    .Y_MAX   (Y_MAX)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int win[$];            // last accepted samples, oldest first
  int p0_v, p0_y, p0_mn, p0_mx;
  int p1_v, p1_y, p1_mn, p1_mx;
  int hold_y, hold_mn, hold_mx;
  int cyc = 0;
  int obs_y[$];
  int obs_cyc[$];

  function automatic void ref_stats(input int w[$], input int rk,
                                    output int y, output int mn, output int mx);
    int s[$];
    int r;
    s = w;
    s.sort();
    r = (rk > N - 1) ? N - 1 : rk;
    y  = s[r];
    mn = s[0];
    mx = s[N-1];
  endfunction

  // Model the filter from the window definition and compare every cycle.
  always @(posedge clk) begin
    int s_rst, s_v, s_x, s_r, e_v;
    s_rst = int'(srst);
    s_v   = int'(x_valid);
    s_x   = int'(X);
    s_r   = int'(rank);
    cyc++;
    if (s_rst == 0) begin
      win.delete();
      p0_v = 0; p1_v = 0;
      hold_y = 0; hold_mn = 0; hold_mx = 0;
      e_v = 0;
    end else begin
      e_v = p1_v;
      if (p1_v != 0) begin
        hold_y = p1_y; hold_mn = p1_mn; hold_mx = p1_mx;
      end
      p1_v = p0_v; p1_y = p0_y; p1_mn = p0_mn; p1_mx = p0_mx;
      p0_v = 0;
      if (s_v != 0) begin
        win.push_back(s_x);
        if (win.size() > N) void'(win.pop_front());
        if (win.size() == N) begin
          ref_stats(win, s_r, p0_y, p0_mn, p0_mx);
          p0_v = 1;
        end
      end
    end
    #1;
    check("y_valid", int'(y_valid), e_v);
    check("Y", int'(Y), hold_y);
`ifdef RANK_FILTER_STATS_EN
    check("Y_MIN", int'(Y_MIN), hold_mn);
    check("Y_MAX", int'(Y_MAX), hold_mx);
`endif
    if (y_valid) begin
      obs_y.push_back(int'(Y));
      obs_cyc.push_back(cyc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int v, input int x, input int rk);
    @(negedge clk);
    x_valid = (v != 0);
    X       = R_WIDTH'(x);
    rank    = RK_W'(rk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, RANK_MEDIAN);
  endtask

  task automatic do_reset();
    @(negedge clk);
    srst    = 1'b0;
    x_valid = 1'b0;
    @(negedge clk);
    srst    = 1'b1;
  endtask

  function automatic int obs_at(input int i);
    return (i < obs_y.size()) ? obs_y[i] : -1;
  endfunction

  // Reset, then the 8-sample sequence with a chosen rank on the last sample.
  task automatic run_seq(input int last_rank);
    do_reset();
    obs_y.delete();
    obs_cyc.delete();
    drive(1, 255, 2); drive(1, 200, 2); drive(1, 10, 2); drive(1, 166, 2);
    drive(1, 131, 2); drive(1, 59, 2);  drive(1, 4, 2);  drive(1, 59, last_rank);
    idle(3);
  endtask

  initial begin
    // Reset state
    srst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_y_valid", int'(y_valid), 0);
    check("reset_Y", int'(Y), 0);
    srst = 1'b1;

    // Tests 1 and 2: warm-up then consecutive medians
    run_seq(2);
    check("t1_result_count", obs_y.size(), 4);
    check("t1_first_median", obs_at(0), 166);
    check("t2_y1", obs_at(1), 131);
    check("t2_y2", obs_at(2), 59);
    check("t2_y3", obs_at(3), 59);
    if (obs_cyc.size() == 4)
      check("t2_back_to_back", obs_cyc[3] - obs_cyc[0], 3);
    else
      check("t2_back_to_back_count", obs_cyc.size(), 4);

    // Test 4: gap holds Y, then ties
    idle(3);
    check("t4_gap_y_valid", int'(y_valid), 0);
    check("t4_gap_Y_held", int'(Y), 59);
    obs_y.delete();
    repeat (5) drive(1, 77, 2);
    drive(1, 1, 2);
    drive(1, 200, 4);
    idle(3);
    check("t4_tie_count", obs_y.size(), 7);
    check("t4_tie0", obs_at(0), 59);
    check("t4_tie1", obs_at(1), 59);
    check("t4_tie2", obs_at(2), 77);
    check("t4_tie3", obs_at(3), 77);
    check("t4_tie4", obs_at(4), 77);
    check("t4_after_ties", obs_at(5), 77);
    check("t4_max_rank", obs_at(6), 200);

    // Test 3: rank selection on window {166,131,59,4,59}
    run_seq(0);
    check("t3_rank0", obs_at(3), 4);
    run_seq(4);
    check("t3_rank4", obs_at(3), 166);
    run_seq(7);
    check("t3_rank7_clamped", obs_at(3), 166);
`ifdef RANK_FILTER_STATS_EN
    check("t3_Y_MIN", int'(Y_MIN), 4);
    check("t3_Y_MAX", int'(Y_MAX), 166);
`endif

    // Test 5: reset mid-stream right after a sample, new window only
    drive(1, 9, 2); drive(1, 99, 2); drive(1, 199, 2);
    do_reset();
    obs_y.delete();
    drive(1, 10, 2); drive(1, 50, 2); drive(1, 30, 2); drive(1, 40, 2);
    drive(1, 20, 2);
    idle(3);
    check("t5_result_count", obs_y.size(), 1);
    check("t5_median", obs_at(0), 30);

    // Test 6: random stream, checked by the model every cycle
    for (int i = 0; i < 1000; i++) begin
      int v, x;
      v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      x = (i < 500) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 7));
      drive(v, x, int'($urandom_range(0, (1 << RK_W) - 1)));
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
